// File: rtl/sdm_pdm_tx_pkg.sv
// sdm_pdm_tx_pkg: shared defaults, flag bundle and helpers for the sigma-delta PDM transmitter.
package sdm_pdm_tx_pkg;

    localparam int SDM_DW_DEF         = 8;
    localparam int SDM_OSR_LOG2_DEF   = 4;
    localparam int SDM_DEPTH_LOG2_DEF = 2;

    typedef struct packed {
        logic uf;
        logic of;
    } sdm_flags_t;

    // Two's complement to offset binary is a flip of the sign bit.
    function automatic logic [31:0] offset_bin(input logic [31:0] s, input int dw);
        return s ^ (32'd1 << (dw - 1));
    endfunction

    function automatic int ptr_w(input int depth_log2);
        return (depth_log2 > 0) ? depth_log2 : 1;
    endfunction

endpackage

// File: rtl/handshake_xor.sv
// handshake_xor: two-flop synchroniser plus XOR edge detector; every input transition
// yields a one-clk tick three clk edges later.
module handshake_xor (
    input  logic clk,
    input  logic rstn,
    input  logic setn,
    input  logic d,
    output logic tick
);

    logic [2:0] sync_q;
    logic       tick_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            tick_q <= 1'b0;
        end else if (!setn) begin
            sync_q <= '1;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], d};
            tick_q <= sync_q[1] ^ sync_q[2];
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/sdm_fifo.sv
// sdm_fifo: small synchronous FIFO with occupancy count; push ignored when full,
// pop ignored when empty, clear flushes everything.
module sdm_fifo
    import sdm_pdm_tx_pkg::*;
#(
    parameter int DW         = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DW-1:0]         wdata,
    output logic [DW-1:0]         rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int PW    = ptr_w(DEPTH_LOG2);
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic          wr_en, rd_en;

    always_comb begin
        full  = lvl_q == LW'(DEPTH);
        empty = lvl_q == '0;
        wr_en = push & ~full;
        rd_en = pop & ~empty;
        wr_d  = !wr_en ? wr_q : (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        rd_d  = !rd_en ? rd_q : (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        lvl_d = (wr_en && !rd_en) ? lvl_q + 1'b1 :
                (rd_en && !wr_en) ? lvl_q - 1'b1 : lvl_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else if (clear) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clear)
            mem_q[wr_q] <= wdata;
    end

    assign rdata = mem_q[rd_q];
    assign level = lvl_q;

endmodule

// File: rtl/sdm_pdm_tx.sv
// sdm_pdm_tx: first-order sigma-delta pulse-density transmitter; buffers signed samples
// and emits 2**OSR_LOG2 bits per sample, one per fclk transition.
module sdm_pdm_tx
    import sdm_pdm_tx_pkg::*;
#(
    parameter int DW         = SDM_DW_DEF,
    parameter int OSR_LOG2   = SDM_OSR_LOG2_DEF,
    parameter int DEPTH_LOG2 = SDM_DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DW-1:0]         wdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    input  logic                  fclk,
    output logic                  frame,
    output logic                  underflow,
    output logic                  overflow,
    output logic                  tx
);

    logic                tick, load, pop;
    logic [DW-1:0]       head, smp_d, smp_q, u, acc_q;
    logic [DW:0]         sum;
    logic [OSR_LOG2-1:0] bit_q;
    logic                tx_q;
    sdm_flags_t          flg_q, flg_d;

    handshake_xor u_tick (
        .clk  (clk),
        .rstn (rstn),
        .setn (1'b1),
        .d    (fclk),
        .tick (tick)
    );

    sdm_fifo #(
        .DW         (DW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // The freshly loaded sample feeds the same tick's bit through the bypass.
    always_comb begin
        load     = tick & ~clear & (bit_q == '0);
        pop      = load & ~empty;
        smp_d    = load ? (empty ? '0 : head) : smp_q;
        u        = DW'(offset_bin(32'(smp_d), DW));
        sum      = {1'b0, acc_q} + {1'b0, u};
        flg_d.uf = flg_q.uf | (load & empty);
        flg_d.of = flg_q.of | (push & full & ~clear);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            smp_q <= '0;
            acc_q <= '0;
            bit_q <= '0;
            tx_q  <= 1'b0;
            flg_q <= '0;
        end else if (clear) begin
            smp_q <= '0;
            acc_q <= '0;
            bit_q <= '0;
            tx_q  <= 1'b0;
            flg_q <= '0;
        end else begin
            flg_q <= flg_d;
            if (tick) begin
                smp_q <= smp_d;
                acc_q <= sum[DW-1:0];
                tx_q  <= sum[DW];
                bit_q <= bit_q + 1'b1;
            end
        end
    end

    assign frame     = load;
    assign underflow = flg_q.uf;
    assign overflow  = flg_q.of;
    assign tx        = tx_q;

endmodule
